// File: rtl/dice_disp_pkg.sv
// Shared types and helpers for the DICE thread-block dispatcher.
package dice_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_TAIL,
    S_DONE
  } disp_state_e;

  localparam int DISP_DRAIN_GUARD_MIN = 2;
  localparam int DISP_WB_TAIL_MIN     = 1;

  // Block size from its dimensions, clipped to the per-block thread limit.
  function automatic logic [31:0] sat_total(input logic [31:0] ntid_x,
                                            input logic [31:0] ntid_y,
                                            input logic [31:0] ntid_z,
                                            input logic [31:0] num_tid);
    logic [95:0] prod;
    prod = {64'd0, ntid_x} * {64'd0, ntid_y} * {64'd0, ntid_z};
    return (prod > {64'd0, num_tid}) ? num_tid : 32'(prod);
  endfunction

endpackage

// File: rtl/dice_tid_coord_ctr.sv
// Linear thread pointer with x/y/z coordinate counters that wrap on block dimensions.
module dice_tid_coord_ctr
  import dice_disp_pkg::*;
#(
  parameter int TID_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 adv,
  input  logic                 hold,
  input  logic [TID_WIDTH-1:0] ntid_x,
  input  logic [TID_WIDTH-1:0] ntid_y,
  input  logic [TID_WIDTH:0]   total,
  output logic [TID_WIDTH-1:0] ptr,
  output logic [TID_WIDTH-1:0] x,
  output logic [TID_WIDTH-1:0] y,
  output logic [TID_WIDTH-1:0] z,
  output logic                 last
);

  localparam int TW1 = TID_WIDTH + 1;

  logic x_wrap;
  logic y_wrap;

  assign x_wrap = (x == ntid_x - TID_WIDTH'(1));
  assign y_wrap = (y == ntid_y - TID_WIDTH'(1));
  assign last   = ({1'b0, ptr} == total - TW1'(1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      ptr <= '0;
      x   <= '0;
      y   <= '0;
      z   <= '0;
    end else if (adv && !hold) begin
      ptr <= ptr + TID_WIDTH'(1);
      if (x_wrap) begin
        x <= '0;
        if (y_wrap) begin
          y <= '0;
          z <= z + TID_WIDTH'(1);
        end else begin
          y <= y + TID_WIDTH'(1);
        end
      end else begin
        x <= x + TID_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/dice_tid_dispatcher.sv
// Thread-block dispatcher: scans linear tids, issues active ones to the CGRA,
// then waits for the pipe to drain and write-back to settle before completing.
module dice_tid_dispatcher
  import dice_disp_pkg::*;
#(
  parameter int NUM_TID     = 512,
  parameter int TID_WIDTH   = $clog2(NUM_TID),
  parameter int WB_TAIL     = 8,
  parameter int DRAIN_GUARD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [NUM_TID-1:0]   start_mask,
  input  logic [TID_WIDTH-1:0] start_ntid_x,
  input  logic [TID_WIDTH-1:0] start_ntid_y,
  input  logic [TID_WIDTH-1:0] start_ntid_z,
  input  logic                 stall,
  output logic                 disp_valid,
  output logic [TID_WIDTH-1:0] disp_tid,
  output logic [TID_WIDTH-1:0] tid_x,
  output logic [TID_WIDTH-1:0] tid_y,
  output logic [TID_WIDTH-1:0] tid_z,
  input  logic                 cgra_done,
  output logic                 busy,
  output logic                 block_done,
  output logic [TID_WIDTH:0]   issued_count
);

  localparam int TW1   = TID_WIDTH + 1;
  localparam int GUARD = (DRAIN_GUARD < DISP_DRAIN_GUARD_MIN) ? DISP_DRAIN_GUARD_MIN : DRAIN_GUARD;
  localparam int TAIL  = (WB_TAIL < DISP_WB_TAIL_MIN) ? DISP_WB_TAIL_MIN : WB_TAIL;

  disp_state_e state, state_nxt;

  logic                 abort;
  logic                 accept;
  logic                 scan_adv;
  logic [TID_WIDTH:0]   total_d;
  logic [TID_WIDTH:0]   total_q;
  logic [NUM_TID-1:0]   mask_q;
  logic [TID_WIDTH-1:0] ntid_x_q;
  logic [TID_WIDTH-1:0] ntid_y_q;
  logic [TID_WIDTH-1:0] ptr;
  logic [TID_WIDTH-1:0] cx, cy, cz;
  logic                 last;
  logic [15:0]          guard_cnt;
  logic [15:0]          tail_cnt;

  assign abort       = rst || clr;
  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign block_done  = (state == S_DONE);
  assign accept      = start_valid && start_ready && !abort;
  assign scan_adv    = (state == S_ISSUE) && !stall;
  assign total_d     = TW1'(sat_total(32'(start_ntid_x), 32'(start_ntid_y),
                                      32'(start_ntid_z), 32'(NUM_TID)));

  dice_tid_coord_ctr #(.TID_WIDTH(TID_WIDTH)) u_coord (
    .clk    (clk),
    .rst    (abort),
    .load   (accept),
    .adv    (state == S_ISSUE),
    .hold   (stall),
    .ntid_x (ntid_x_q),
    .ntid_y (ntid_y_q),
    .total  (total_q),
    .ptr    (ptr),
    .x      (cx),
    .y      (cy),
    .z      (cz),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (abort) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_valid) state_nxt = (total_d == '0) ? S_DRAIN : S_ISSUE;
      S_ISSUE: if (!stall && last) state_nxt = S_DRAIN;
      S_DRAIN: if (guard_cnt == 16'(GUARD) && cgra_done) state_nxt = S_TAIL;
      S_TAIL:  if (tail_cnt == 16'(TAIL - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Launch descriptor capture
  always_ff @(posedge clk) begin
    if (accept) begin
      mask_q   <= start_mask;
      ntid_x_q <= start_ntid_x;
      ntid_y_q <= start_ntid_y;
      total_q  <= total_d;
    end
  end

  // Issue stage: scan result registered onto disp_*
  always_ff @(posedge clk) begin
    if (abort) begin
      disp_valid   <= 1'b0;
      disp_tid     <= '0;
      tid_x        <= '0;
      tid_y        <= '0;
      tid_z        <= '0;
      issued_count <= '0;
      guard_cnt    <= '0;
      tail_cnt     <= '0;
    end else begin
      disp_valid <= 1'b0;
      if (accept) issued_count <= '0;
      if (scan_adv && mask_q[ptr]) begin
        disp_valid   <= 1'b1;
        disp_tid     <= ptr;
        tid_x        <= cx;
        tid_y        <= cy;
        tid_z        <= cz;
        issued_count <= issued_count + TW1'(1);
      end
      if (state != S_DRAIN)              guard_cnt <= '0;
      else if (guard_cnt != 16'(GUARD))  guard_cnt <= guard_cnt + 16'd1;
      if (state != S_TAIL) tail_cnt <= '0;
      else                 tail_cnt <= tail_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dice_tid_dispatcher.sv
// Scoreboard bench for dice_tid_dispatcher: expected issues queued at launch, checked as they appear.
`timescale 1ns/1ps
module tb_dice_tid_dispatcher;

  localparam int NUM_TID = 512;
  localparam int TW      = 9;
  localparam int WB      = 8;
  localparam int DG      = 2;

  logic               clk = 1'b0;
  logic               rst, clr, start_valid, stall, cgra_done;
  logic [NUM_TID-1:0] start_mask;
  logic [TW-1:0]      start_ntid_x, start_ntid_y, start_ntid_z;
  logic               start_ready, disp_valid, busy, block_done;
  logic [TW-1:0]      disp_tid, tid_x, tid_y, tid_z;
  logic [TW:0]        issued_count;

  typedef struct packed {
    logic [31:0] tid;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] cyc;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        ob, ex;
  logic        got, have_ex;
  int          tests = 0;
  int          fails = 0;
  int          done_seen;
  int          done_cyc;
  logic [31:0] cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dice_tid_dispatcher #(
    .NUM_TID(NUM_TID), .TID_WIDTH(TW), .WB_TAIL(WB), .DRAIN_GUARD(DG)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .start_valid(start_valid), .start_ready(start_ready), .start_mask(start_mask),
    .start_ntid_x(start_ntid_x), .start_ntid_y(start_ntid_y), .start_ntid_z(start_ntid_z),
    .stall(stall), .disp_valid(disp_valid), .disp_tid(disp_tid),
    .tid_x(tid_x), .tid_y(tid_y), .tid_z(tid_z), .cgra_done(cgra_done),
    .busy(busy), .block_done(block_done), .issued_count(issued_count)
  );

  // Advance one cycle, sample on the falling edge, pop the matching scoreboard entry.
  task automatic step();
    @(negedge clk);
    got = disp_valid; have_ex = 1'b0; ob = '0; ex = '0;
    if (disp_valid) begin
      ob = {32'(disp_tid), 32'(tid_x), 32'(tid_y), 32'(tid_z), cyc};
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        have_ex = 1'b1;
      end
    end
    if (block_done) begin
      done_seen++;
      done_cyc = int'(cyc);
    end
  endtask

  task automatic show_issue(input string name);
    $display("FAIL %s: got tid=%0d xyz=(%0d,%0d,%0d) cyc=%0d, want tid=%0d xyz=(%0d,%0d,%0d) cyc=%0d (have=%0b)",
             name, ob.tid, ob.x, ob.y, ob.z, ob.cyc, ex.tid, ex.x, ex.y, ex.z, ex.cyc, have_ex);
  endtask

  // Independent model: linear index -> coordinates by division, one scan per unstalled cycle.
  task automatic push_model(input int nx, input int ny, input int nz, input logic [NUM_TID-1:0] m,
                            input int a, input int sidx, input int slen, output int l);
    int tot;
    int c;
    tot = nx * ny * nz;
    if (tot > NUM_TID) tot = NUM_TID;
    for (int i = 0; i < tot; i++) begin
      c = a + 1 + i + ((i >= sidx) ? slen : 0);
      if (m[i]) exp_q.push_back({32'(i), 32'(i % nx), 32'((i / nx) % ny), 32'(i / (nx * ny)), 32'(c)});
    end
    l = a + tot - 1 + ((tot > sidx) ? slen : 0);
  endtask

  task automatic launch(input int nx, input int ny, input int nz, input logic [NUM_TID-1:0] m,
                        output int a);
    step();
    start_valid  = 1'b1;
    start_mask   = m;
    start_ntid_x = TW'(nx);
    start_ntid_y = TW'(ny);
    start_ntid_z = TW'(nz);
    step();
    start_valid = 1'b0;
    a = int'(cyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; start_valid = 1'b0; stall = 1'b0; cgra_done = 1'b1;
    start_mask = '0; start_ntid_x = '0; start_ntid_y = '0; start_ntid_z = '0;
    step(); step();
    rst = 1'b0;
    step();
    tests++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || block_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b, want 1 0 0", start_ready, busy, block_done);
    end
    tests++;
    if (disp_valid !== 1'b0 || disp_tid !== '0) begin
      fails++;
      $display("FAIL reset_disp: got valid=%b tid=%0d, want 0 0", disp_valid, disp_tid);
    end
    tests++;
    if (tid_x !== '0 || tid_y !== '0 || tid_z !== '0 || issued_count !== '0) begin
      fails++;
      $display("FAIL reset_coord: got xyz=(%0d,%0d,%0d) cnt=%0d, want 0", tid_x, tid_y, tid_z, issued_count);
    end
  endtask

  task automatic test_full_block();
    int a, l;
    exp_q.delete(); done_seen = 0; cgra_done = 1'b1;
    launch(4, 2, 1, {NUM_TID{1'b1}}, a);
    push_model(4, 2, 1, {NUM_TID{1'b1}}, a, 1 << 20, 0, l);
    tests++;
    if (busy !== 1'b1 || start_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_busy: got busy=%b ready=%b, want 1 0", busy, start_ready);
    end
    for (int k = 0; k < 100 && done_seen == 0; k++) begin
      step();
      if (got) begin
        tests++;
        if (!have_ex || ob !== ex) begin fails++; show_issue("full_issue"); end
      end
    end
    tests++;
    if (exp_q.size() != 0 || done_seen != 1 || done_cyc != l + DG + WB + 2) begin
      fails++;
      $display("FAIL full_done: got left=%0d done=%0d at %0d, want 0 1 at %0d",
               exp_q.size(), done_seen, done_cyc, l + DG + WB + 2);
    end
    tests++;
    if (issued_count !== 10'd8) begin
      fails++;
      $display("FAIL full_count: got %0d, want 8", issued_count);
    end
  endtask

  task automatic test_sparse_mask();
    int a, l;
    logic [NUM_TID-1:0] m;
    m = '0;
    m[7:0] = 8'hA5;
    m[300] = 1'b1;
    exp_q.delete(); done_seen = 0; cgra_done = 1'b1;
    launch(4, 2, 1, m, a);
    push_model(4, 2, 1, m, a, 1 << 20, 0, l);
    for (int k = 0; k < 100 && done_seen == 0; k++) begin
      step();
      if (got) begin
        tests++;
        if (!have_ex || ob !== ex) begin fails++; show_issue("sparse_issue"); end
      end
    end
    tests++;
    if (exp_q.size() != 0 || issued_count !== 10'd4 || done_cyc != l + DG + WB + 2) begin
      fails++;
      $display("FAIL sparse_done: got left=%0d cnt=%0d done at %0d, want 0 4 at %0d",
               exp_q.size(), issued_count, done_cyc, l + DG + WB + 2);
    end
  endtask

  task automatic test_stall();
    int a, l, gaps;
    exp_q.delete(); done_seen = 0; cgra_done = 1'b1; gaps = 0;
    launch(3, 3, 2, {NUM_TID{1'b1}}, a);
    push_model(3, 3, 2, {NUM_TID{1'b1}}, a, 4, 3, l);
    for (int k = 0; k < 150 && done_seen == 0; k++) begin
      step();
      if (int'(cyc) == a + 4) stall = 1'b1;
      if (int'(cyc) == a + 7) stall = 1'b0;
      if (!got && int'(cyc) >= a + 1 && int'(cyc) <= l + 1) gaps++;
      if (got) begin
        tests++;
        if (!have_ex || ob !== ex) begin fails++; show_issue("stall_issue"); end
      end
    end
    stall = 1'b0;
    tests++;
    if (gaps != 3 || exp_q.size() != 0 || issued_count !== 10'd18) begin
      fails++;
      $display("FAIL stall_gaps: got gaps=%0d left=%0d cnt=%0d, want 3 0 18", gaps, exp_q.size(), issued_count);
    end
    tests++;
    if (done_seen != 1 || done_cyc != l + DG + WB + 2) begin
      fails++;
      $display("FAIL stall_done: got %0d at %0d, want 1 at %0d", done_seen, done_cyc, l + DG + WB + 2);
    end
  endtask

  task automatic test_zero_size();
    int a, l;
    exp_q.delete(); done_seen = 0; cgra_done = 1'b1;
    launch(4, 2, 0, {NUM_TID{1'b1}}, a);
    push_model(4, 2, 0, {NUM_TID{1'b1}}, a, 1 << 20, 0, l);
    for (int k = 0; k < 60 && done_seen == 0; k++) begin
      step();
      if (got) begin
        tests++;
        if (!have_ex || ob !== ex) begin fails++; show_issue("zero_issue"); end
      end
    end
    tests++;
    if (done_seen != 1 || done_cyc != a + 11 || issued_count !== '0) begin
      fails++;
      $display("FAIL zero_done: got %0d at %0d cnt=%0d, want 1 at %0d cnt=0",
               done_seen, done_cyc, issued_count, a + 11);
    end
  endtask

  task automatic test_late_done();
    int a, l;
    exp_q.delete(); done_seen = 0; cgra_done = 1'b0;
    launch(2, 2, 1, {NUM_TID{1'b1}}, a);
    push_model(2, 2, 1, {NUM_TID{1'b1}}, a, 1 << 20, 0, l);
    for (int k = 0; k < 100 && done_seen == 0; k++) begin
      step();
      if (int'(cyc) == l + 10) cgra_done = 1'b1;
      if (got) begin
        tests++;
        if (!have_ex || ob !== ex) begin fails++; show_issue("late_issue"); end
      end
    end
    tests++;
    if (done_seen != 1 || done_cyc != l + 10 + WB + 1) begin
      fails++;
      $display("FAIL late_done: got %0d at %0d, want 1 at %0d", done_seen, done_cyc, l + 10 + WB + 1);
    end
    cgra_done = 1'b1;
  endtask

  task automatic test_abort_relaunch();
    int a, l, stray;
    exp_q.delete(); done_seen = 0; cgra_done = 1'b1; stray = 0;
    launch(4, 2, 1, {NUM_TID{1'b1}}, a);
    step(); step(); step();
    start_valid = 1'b1; start_ntid_x = TW'(2); start_ntid_y = TW'(1); start_ntid_z = TW'(1);
    tests++;
    if (start_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy: got ready=%b busy=%b, want 0 1", start_ready, busy);
    end
    step();
    clr = 1'b1;
    step();
    clr = 1'b0; start_valid = 1'b0;
    tests++;
    if (disp_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 || issued_count !== '0) begin
      fails++;
      $display("FAIL abort_state: got valid=%b ready=%b busy=%b cnt=%0d, want 0 1 0 0",
               disp_valid, start_ready, busy, issued_count);
    end
    for (int k = 0; k < 25; k++) begin
      step();
      if (got) stray++;
    end
    tests++;
    if (stray != 0 || done_seen != 0) begin
      fails++;
      $display("FAIL abort_quiet: got issues=%0d done=%0d, want 0 0", stray, done_seen);
    end
    launch(2, 1, 1, {NUM_TID{1'b1}}, a);
    push_model(2, 1, 1, {NUM_TID{1'b1}}, a, 1 << 20, 0, l);
    for (int k = 0; k < 60 && done_seen == 0; k++) begin
      step();
      if (got) begin
        tests++;
        if (!have_ex || ob !== ex) begin fails++; show_issue("relaunch_issue"); end
      end
    end
    tests++;
    if (exp_q.size() != 0 || issued_count !== 10'd2 || done_seen != 1 || done_cyc != l + DG + WB + 2) begin
      fails++;
      $display("FAIL relaunch_done: got left=%0d cnt=%0d done=%0d at %0d, want 0 2 1 at %0d",
               exp_q.size(), issued_count, done_seen, done_cyc, l + DG + WB + 2);
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_sparse_mask();
    test_stall();
    test_zero_size();
    test_late_done();
    test_abort_relaunch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dice_tid_dispatcher.md
# dice_tid_dispatcher

Drives the dispatch side of the DICE CGRA subsystem for one thread block. It accepts a launch descriptor (block dimensions plus an active-thread mask) and scans thread IDs in linear order, one per cycle. For each active thread it issues `disp_tid`, `disp_valid` and the decomposed `tid_x/y/z` to the CGRA subsystem. It then waits for the subsystem's `done` and a write-back tail before signalling block completion.

## Interface
Parameters:
- `NUM_TID`, 512: maximum threads per block.
- `TID_WIDTH`, `$clog2(NUM_TID)`: thread-ID width.
- `WB_TAIL`, 8: cycles waited after `cgra_done` for RF write-back latency to drain (≥1).
- `DRAIN_GUARD`, 2: cycles after the last scan during which `cgra_done` is ignored (≥2).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `clr`  in  1  synchronous abort; same effect as `rst`.
- `start_valid`  in  1  launch request.
- `start_ready`  out  1  high only in IDLE.
- `start_mask`  in  NUM_TID  active-thread mask; bit i is linear tid i.
- `start_ntid_x/y/z`  in  TID_WIDTH each  block dimensions.
- `stall`  in  1  backpressure; the scan does not advance.
- `disp_valid`  out  1  registered; one issued thread.
- `disp_tid`  out  TID_WIDTH  linear tid.
- `tid_x`, `tid_y`, `tid_z`  out  TID_WIDTH each  coordinates of `disp_tid`.
- `cgra_done`  in  1  CGRA pipe empty.
- `busy`  out  1  state ≠ IDLE.
- `block_done`  out  1  one-cycle completion pulse.
- `issued_count`  out  TID_WIDTH+1  number of `disp_valid` pulses since the last accept.

## Operation
- States are IDLE, ISSUE, DRAIN, TAIL and DONE.
- **IDLE**
  - On `start_valid && start_ready`, latch the mask and ntid values.
  - Compute `total = ntid_x*ntid_y*ntid_z` at 3×TID_WIDTH bits, saturated to NUM_TID.
  - Clear the scan pointer, the x/y/z counters and `issued_count`.
  - Go to ISSUE, or to DRAIN if `total == 0`.
- **ISSUE**
  - Each cycle with `!stall`: if `mask[ptr]`, register the issue (`disp_valid=1`, `disp_tid=ptr`, coordinates = counters) and increment `issued_count`.
  - On every non-stalled cycle, advance ptr and the counters whether or not the thread is active. Inactive threads therefore cost one cycle each.
  - Counter rule: `x==ntid_x-1` wraps x to 0 and increments y. `y==ntid_y-1` at the same time wraps y to 0 and increments z.
  - When the scanned `ptr == total-1` (and not stalled), go to DRAIN.
  - Mask bits at or above `total` are ignored.
  - With `stall=1`: ptr and counters hold, `disp_valid=0` next cycle, and `disp_tid`/coordinates hold their last values.
- **DRAIN**
  - A guard counter runs for DRAIN_GUARD cycles. After it expires, a sampled `cgra_done=1` moves the state to TAIL.
  - The guard exists because the subsystem's `done` only falls one cycle after a `disp_valid`.
- **TAIL**: count WB_TAIL cycles, then go to DONE.
- **DONE**: `block_done=1` for exactly one cycle, then go to IDLE.
- `start_valid` outside IDLE is ignored; the request is not queued.
- `stall` outside ISSUE has no effect.
- **rst/clr** at any cycle:
  - next state is IDLE;
  - `disp_valid=0` and `block_done=0` next cycle, and no completion pulse is emitted for the aborted block;
  - `issued_count` clears.
  - If `clr` and `start_valid` arrive in the same cycle, `clr` wins and the start is dropped.
- **Reset values of outputs**:
  - `start_ready=1`;
  - `disp_valid=0`, `disp_tid=0`, `tid_x/y/z=0`;
  - `busy=0`, `block_done=0`, `issued_count=0`.

## Timing
- Accept at edge A puts the block in ISSUE during cycle A+1. The first tid scanned in A+1 is visible on `disp_*` in cycle A+2.
- Throughput: one scanned tid per non-stalled cycle. All `disp_*` outputs are registered with 1-cycle latency from scan.
- Last scan in cycle L puts the block in DRAIN at L+1. `cgra_done` is first honoured at cycle L+1+DRAIN_GUARD.
- If `cgra_done` is first sampled high at cycle D (post-guard), TAIL covers D+1 through D+WB_TAIL and `block_done` is high at D+WB_TAIL+1.
- `start_ready` is combinational from state. The earliest next accept is the cycle after `block_done`.

## Structure
- **Package `dice_disp_pkg`**:
  - state enum `disp_state_e`;
  - function `sat_total(ntid_x, ntid_y, ntid_z)`;
  - shared constants `DISP_DRAIN_GUARD_MIN = 2` and `DISP_WB_TAIL_MIN = 1`.
- **Sub-module `dice_tid_coord_ctr`**: the x/y/z wrap counter with load, advance and hold controls, plus `last` output (`ptr == total-1`). The top level holds the FSM, mask register, output registers and tail/guard counters.

## Test plan
- **Full 4×2×1 block**: ntid 4×2×1, mask all ones, no stall -> `disp_tid` 0..7 on cycles A+2..A+9, `tid_x` 0,1,2,3,0,1,2,3, `tid_y` 0,0,0,0,1,1,1,1, `issued_count=8`.
- **Sparse mask**: same dims, mask 0xA5 -> tids 0,2,5,7 with (x,y) = (0,0),(2,0),(1,1),(3,1), issued on cycles A+2, A+4, A+7, A+9.
- **Stall mid-scan**: 3×3×2 all active, `stall` high for 3 cycles mid-scan -> 3 cycles with `disp_valid=0`, 18 tids total, none duplicated or skipped, last tid 17 = (2,2,1).
- **Zero-size block**: `ntid_z=0` -> no `disp_valid`, `cgra_done=1` throughout -> `block_done` at A+1+DRAIN_GUARD+WB_TAIL+1 (A+12 with defaults, DRAIN state entered at A+1).
- **Late CGRA done**: `cgra_done` held low until 10 cycles after the last scan -> `block_done` exactly WB_TAIL+1 cycles after `cgra_done` is first sampled high.
- **Abort and relaunch**: `clr` during ISSUE -> next cycle `disp_valid=0`, `start_ready=1`, no `block_done`; a following launch with 2×1×1 issues tids 0,1 correctly. A `start_valid` while `busy` is ignored.
